uart_rx_8n1: RTL and testbench

- Asynchronous serial receiver for 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); the line idles high.
- Oversamples the line with the system clock and samples each bit at its centre.
- Presents each received byte with a one-cycle valid strobe.
- Sits between the external RX pin and the byte-level consumer logic.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx_8n1.sv | 119 +++++++++++
 tb/tb_uart_rx_8n1.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 108;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous input; flops preset to 1 so an idle
// UART line is seen as idle straight out of reset.
module uart_sync #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '1;
    else          r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver, centre-sampling with the system clock.
// Optional macro UART_RX_FRAME_ERR_EN adds the uart_frame_err pulse output.
//
// state | meaning
// IDLE  | waiting for a falling edge (blocked while the break flag is set)
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits at their centres, LSB first
// STOP  | sampling the stop bit; good frame -> DONE, framing error -> IDLE
// DONE  | one-cycle valid strobe
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      uart_clock,
  input  logic                      uart_reset,
  input  logic                      uart_d_in,
  output logic [UART_DATA_BITS-1:0] uart_d_out,
  output logic                      uart_valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                      uart_frame_err
`endif
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  rx_state_t                 r_state;
  logic [CW-1:0]             r_clk_cnt;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_d_out;
  logic                      r_valid;
  logic                      r_break;
  logic                      r_frame_err;

  uart_sync #(.N(SYNC_STAGES)) u_sync (
    .i_clk   (uart_clock),
    .i_rst_n (uart_reset),
    .i_d     (uart_d_in),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_d_out     <= '0;
      r_valid     <= 1'b0;
      r_break     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_rx_s) r_break <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          if (!w_rx_s && !r_break) r_state <= START;
        end
        START: begin
          if (r_clk_cnt == HALF_CNT) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == LAST_BIT) r_state   <= STOP;
            else                       r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              r_d_out <= r_shift;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              // Line still low: hold off re-arming until it has gone high.
              r_break     <= 1'b1;
              r_frame_err <= 1'b1;
              r_state     <= IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign uart_d_out = r_d_out;
  assign uart_valid = r_valid;
`ifdef UART_RX_FRAME_ERR_EN
  assign uart_frame_err = r_frame_err;
`else
  logic w_unused_frame_err;
  assign w_unused_frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1; expected bytes are queued at stimulus
// time and matched against bytes captured on each uart_valid strobe.
module tb_uart_rx_8n1;

  localparam int BIT_NS = 2170;

  logic       uart_clock = 1'b0;
  logic       uart_reset;
  logic       uart_d_in;
  logic [7:0] uart_d_out;
  logic       uart_valid;
`ifdef UART_RX_FRAME_ERR_EN
  logic       uart_frame_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       prev_valid = 1'b0;
  int         long_pulse = 0;
  int         ferr_cnt   = 0;
  int         ferr_overlap = 0;
  time        last_valid_t = 0;
  time        t_start = 0;

  uart_rx_8n1 #(.CLKS_PER_BIT(108), .SYNC_STAGES(2)) dut (
    .uart_clock (uart_clock),
    .uart_reset (uart_reset),
    .uart_d_in  (uart_d_in),
    .uart_d_out (uart_d_out),
    .uart_valid (uart_valid)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .uart_frame_err (uart_frame_err)
`endif
  );

  always #10 uart_clock = ~uart_clock;

  always @(negedge uart_clock) begin
    if (uart_reset === 1'b1) begin
      if (uart_valid === 1'b1) begin
        got_q.push_back(uart_d_out);
        if (!prev_valid) last_valid_t = $time;
        if (prev_valid) long_pulse++;
      end
`ifdef UART_RX_FRAME_ERR_EN
      if (uart_frame_err === 1'b1) ferr_cnt++;
      if (uart_frame_err === 1'b1 && uart_valid === 1'b1) ferr_overlap++;
`endif
    end
    prev_valid = uart_valid;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    t_start   = $time;
    uart_d_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_d_in = b[i];
      #(BIT_NS);
    end
    uart_d_in = stop_bit;
    #(BIT_NS);
    uart_d_in = 1'b1;
  endtask

  task automatic test_reset;
    int bad_valid;
    int bad_dout;
    bad_valid  = 0;
    bad_dout   = 0;
    uart_d_in  = 1'b1;
    uart_reset = 1'b0;
    repeat (2500) begin
      @(negedge uart_clock);
      if (uart_valid !== 1'b0) bad_valid++;
      if (uart_d_out !== 8'h00) bad_dout++;
    end
    n_vec++;
    if (bad_valid !== 0) begin n_miss++; $display("FAIL reset_valid: %0d cycles with valid high, required 0", bad_valid); end
    n_vec++;
    if (bad_dout !== 0) begin n_miss++; $display("FAIL reset_dout: %0d cycles with d_out nonzero, required 0", bad_dout); end
    uart_reset = 1'b1;
    #10000;
    n_vec++;
    if (got_q.size() !== 0) begin n_miss++; $display("FAIL reset_idle_pulses: got %0d, required 0", got_q.size()); end
    n_vec++;
    if (uart_d_out !== 8'h00) begin n_miss++; $display("FAIL reset_idle_dout: got %h, required 00", uart_d_out); end
  endtask

  task automatic test_single;
    logic [7:0] e;
    logic [7:0] g;
    time lat;
    time t0;
    exp_q.push_back(8'h45);
    send_frame(8'h45, 1'b1);
    t0 = t_start;
    #100000;
    n_vec++;
    if (got_q.size() !== 1) begin n_miss++; $display("FAIL single_count: got %0d pulses, required 1", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_vec++;
      if (g !== e) begin n_miss++; $display("FAIL single_byte: got %h, required %h", g, e); end
    end
    got_q.delete();
    n_vec++;
    if (uart_d_out !== 8'h45) begin n_miss++; $display("FAIL single_hold: got %h, required 45", uart_d_out); end
    lat = last_valid_t - t0;
    n_vec++;
    if (lat < 20000 || lat > 21200) begin n_miss++; $display("FAIL single_latency: got %0t, required 20000..21200 ns", lat); end
  endtask

  task automatic test_sequence;
    logic [7:0] seq [3];
    logic [7:0] e;
    logic [7:0] g;
    seq[0] = 8'h4C; seq[1] = 8'h45; seq[2] = 8'h44;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq[i]);
      send_frame(seq[i], 1'b1);
      #100000;
    end
    n_vec++;
    if (got_q.size() !== 3) begin n_miss++; $display("FAIL seq_count: got %0d pulses, required 3", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_vec++;
      if (g !== e) begin n_miss++; $display("FAIL seq_byte: got %h, required %h", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    logic [7:0] g;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    #30000;
    n_vec++;
    if (got_q.size() !== 2) begin n_miss++; $display("FAIL b2b_count: got %0d pulses, required 2", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_vec++;
      if (g !== e) begin n_miss++; $display("FAIL b2b_byte: got %h, required %h", g, e); end
    end
    got_q.delete();
    n_vec++;
    if (long_pulse !== 0) begin n_miss++; $display("FAIL valid_width: %0d extra valid cycles, required 0", long_pulse); end
  endtask

  task automatic test_glitch;
    logic [7:0] g;
    uart_d_in = 1'b0;
    repeat (20) @(posedge uart_clock);
    uart_d_in = 1'b1;
    #20000;
    n_vec++;
    if (got_q.size() !== 0) begin n_miss++; $display("FAIL glitch_pulses: got %0d, required 0", got_q.size()); end
    n_vec++;
    if (uart_d_out !== 8'hAA) begin n_miss++; $display("FAIL glitch_dout: got %h, required aa", uart_d_out); end
    got_q.delete();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    #30000;
    g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    n_vec++;
    if (g !== exp_q[0] || got_q.size() !== 0) begin n_miss++; $display("FAIL glitch_next_byte: got %h, required %h once", g, exp_q[0]); end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_frame_err;
    logic [7:0] g;
    ferr_cnt = 0;
    send_frame(8'hFF, 1'b0);
    uart_d_in = 1'b0;
    #(3 * BIT_NS);
    uart_d_in = 1'b1;
    #20000;
    n_vec++;
    if (got_q.size() !== 0) begin n_miss++; $display("FAIL ferr_pulses: got %0d, required 0", got_q.size()); end
    n_vec++;
    if (uart_d_out !== 8'h3C) begin n_miss++; $display("FAIL ferr_dout: got %h, required 3c", uart_d_out); end
`ifdef UART_RX_FRAME_ERR_EN
    n_vec++;
    if (ferr_cnt !== 1) begin n_miss++; $display("FAIL ferr_strobe: got %0d pulses, required 1", ferr_cnt); end
    n_vec++;
    if (ferr_overlap !== 0) begin n_miss++; $display("FAIL ferr_overlap: got %0d, required 0", ferr_overlap); end
`endif
    got_q.delete();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    #30000;
    g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    n_vec++;
    if (g !== exp_q[0] || got_q.size() !== 0) begin n_miss++; $display("FAIL ferr_recover_byte: got %h, required %h once", g, exp_q[0]); end
    exp_q.delete();
    n_vec++;
    if (uart_d_out !== 8'h81) begin n_miss++; $display("FAIL ferr_recover_dout: got %h, required 81", uart_d_out); end
  endtask

  initial begin
    uart_reset = 1'b0;
    uart_d_in  = 1'b1;
    test_reset();
    test_single();
    test_sequence();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
